// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and width helpers for the keypad scanner
package keypad_pkg;

    // Scanner FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PUSH,
        ST_RELEASE
    } state_t;

    // Ceiling log2, never below 1 so it can size any vector
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Key-code width for a rows x cols matrix
    function automatic int code_w(input int rows, input int cols);
        return clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_code_fifo.sv
// rtl/keypad_code_fifo.sv - synchronous key-code FIFO with registered head
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   push/push_data write request and data (ignored when full unless popping)
//   pop            read request (ignored when empty)
//   head           registered head entry
//   not_empty      FIFO holds at least one entry
//   full           FIFO holds DEPTH entries
module keypad_code_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             full
);

    localparam int AW = clog2(DEPTH);
    localparam int NW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [NW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign not_empty = (count != '0);
    assign full      = (count == NW'(DEPTH));
    assign pop_ok    = pop && not_empty;
    // A full FIFO still accepts a push when the same cycle frees a slot
    assign push_ok   = push && (!full || pop_ok);
    assign rd_next   = rd_ptr + (pop_ok ? AW'(1) : AW'(0));

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
            // The new head comes from the write port when that slot is the
            // one being filled right now (push into an empty-after-pop FIFO)
            if (push_ok && (wr_ptr == rd_next)) begin
                head <= push_data;
            end else begin
                head <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/keypad_scanner_param.sv
// rtl/keypad_scanner_param.sv - parametrised matrix keypad scanner with debounce and code FIFO
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   row             raw asynchronous row lines (1 = connected to a driven column)
//   col             column drive: all ones when idle/releasing, one-hot while scanning
//   code            FIFO head key code = row_idx*COLS + col_idx
//   code_valid      FIFO non-empty
//   code_ready      consumer accepts head when code_valid && code_ready
//   key_held        a key is accepted and not yet released
//   multi_key       one-cycle pulse when a column sample shows several rows
//   overflow        sticky, set when a code is dropped on a full FIFO
module keypad_scanner_param
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    localparam int CODE_W         = code_w(ROWS, COLS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              key_held,
    output logic              multi_key,
    output logic              overflow
);

    localparam int RW = clog2(ROWS);
    localparam int CW = clog2(COLS);
    localparam int SW = clog2(SETTLE_CYCLES + 1);
    localparam int DW = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);

    state_t          state, state_next;
    logic [ROWS-1:0] sync1, s_row;
    logic [CW-1:0]   col_idx, col_idx_next;
    logic [SW-1:0]   settle_cnt, settle_next;
    logic [DW-1:0]   cnt, cnt_next;
    logic [ROWS-1:0] row_hot, row_hot_next;
    logic [RW-1:0]   row_idx, row_idx_next;
    logic [RW-1:0]   row_enc;
    logic            key_held_next, multi_next, overflow_next;
    logic            one_hot;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic [CODE_W-1:0] push_code;

    assign one_hot   = (s_row != '0) && ((s_row & (s_row - ROW_ONE)) == '0);
    assign pop       = code_valid && code_ready;
    assign push_code = CODE_W'(row_idx) * CODE_W'(COLS) + CODE_W'(col_idx);

    always_comb begin
        row_enc = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (s_row[i]) begin
                row_enc = RW'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1      <= '0;
            s_row      <= '0;
            state      <= ST_IDLE;
            col_idx    <= '0;
            settle_cnt <= '0;
            cnt        <= '0;
            row_hot    <= '0;
            row_idx    <= '0;
            key_held   <= 1'b0;
            multi_key  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            sync1      <= row;
            s_row      <= sync1;
            state      <= state_next;
            col_idx    <= col_idx_next;
            settle_cnt <= settle_next;
            cnt        <= cnt_next;
            row_hot    <= row_hot_next;
            row_idx    <= row_idx_next;
            key_held   <= key_held_next;
            multi_key  <= multi_next;
            overflow   <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state;
        col_idx_next  = col_idx;
        settle_next   = settle_cnt;
        cnt_next      = cnt;
        row_hot_next  = row_hot;
        row_idx_next  = row_idx;
        key_held_next = key_held;
        multi_next    = 1'b0;
        overflow_next = overflow;
        push          = 1'b0;
        col           = '1;
        case (state)
            ST_IDLE: begin
                if (s_row != '0) begin
                    state_next   = ST_SCAN;
                    col_idx_next = '0;
                    settle_next  = '0;
                end
            end
            ST_SCAN: begin
                col = COLS'(1) << col_idx;
                if (settle_cnt != SW'(SETTLE_CYCLES)) begin
                    settle_next = settle_cnt + SW'(1);
                end else if (s_row == '0) begin
                    // Nothing on this column; after the last one the key is gone
                    if (col_idx == CW'(COLS - 1)) begin
                        state_next = ST_IDLE;
                    end else begin
                        col_idx_next = col_idx + CW'(1);
                        settle_next  = '0;
                    end
                end else if (one_hot) begin
                    row_hot_next = s_row;
                    row_idx_next = row_enc;
                    cnt_next     = DW'(1);
                    state_next   = ST_DEBOUNCE;
                end else begin
                    multi_next = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_RELEASE;
                end
            end
            ST_DEBOUNCE: begin
                col = COLS'(1) << col_idx;
                if (s_row != row_hot) begin
                    state_next = ST_IDLE;
                end else if (cnt >= DW'(DEBOUNCE_CYCLES)) begin
                    state_next = ST_PUSH;
                end else begin
                    cnt_next = cnt + DW'(1);
                end
            end
            ST_PUSH: begin
                col           = COLS'(1) << col_idx;
                push          = 1'b1;
                key_held_next = 1'b1;
                if (fifo_full && !pop) begin
                    overflow_next = 1'b1;
                end
                cnt_next   = '0;
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (s_row == '0) begin
                    if (cnt >= DW'(DEBOUNCE_CYCLES - 1)) begin
                        key_held_next = 1'b0;
                        cnt_next      = '0;
                        state_next    = ST_IDLE;
                    end else begin
                        cnt_next = cnt + DW'(1);
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    keypad_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_code),
        .pop       (pop),
        .head      (code),
        .not_empty (code_valid),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_keypad_scanner_param.sv
// tb/tb_keypad_scanner_param.sv - self-checking bench for keypad_scanner_param
module tb_keypad_scanner_param;

    logic             clock = 1'b0;
    logic             reset;
    logic [3:0]       row;
    logic [3:0]       col;
    logic [3:0]       code;
    logic             code_valid;
    logic             code_ready;
    logic             key_held;
    logic             multi_key;
    logic             overflow;
    logic [3:0][3:0]  keys;

    int tests_run    = 0;
    int tests_failed = 0;
    int pops         = 0;
    int valid_cycles = 0;
    int multi_seen   = 0;
    int held_seen    = 0;
    logic [3:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [3:0] prev_code  = '0;

    keypad_scanner_param #(
        .ROWS            (4),
        .COLS            (4),
        .SETTLE_CYCLES   (3),
        .DEBOUNCE_CYCLES (4),
        .FIFO_DEPTH      (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .key_held   (key_held),
        .multi_key  (multi_key),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    // Keypad matrix: a row reads 1 when a pressed key on it sits on a driven column
    always_comb begin
        row = '0;
        for (int r = 0; r < 4; r++) begin
            row[r] = |(keys[r] & col);
        end
    end

    // Scoreboard consumer and event counters
    always @(negedge clock) begin
        logic [3:0] e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (multi_key) multi_seen++;
            if (key_held) held_seen++;
            if (code_valid) valid_cycles++;
            if (prev_stall && code_valid) begin
                tests_run++;
                if (code !== prev_code) begin
                    tests_failed++;
                    $display("FAIL code_stable: got %0d required %0d", code, prev_code);
                end
            end
            if (code_valid && code_ready) begin
                pops++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_code: got %0d required none", code);
                end else begin
                    e = exp_q.pop_front();
                    if (code !== e) begin
                        tests_failed++;
                        $display("FAIL code_order: got %0d required %0d", code, e);
                    end
                end
            end
            prev_stall = code_valid && !code_ready;
            prev_code  = code;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        pops         = 0;
        valid_cycles = 0;
        multi_seen   = 0;
        held_seen    = 0;
    endtask

    task automatic press_key(input int r, input int c, input int hold);
        keys[r][c] = 1'b1;
        tick(hold);
        keys[r][c] = 1'b0;
        tick(20);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        tests_run += 6;
        if (col !== 4'b1111) begin tests_failed++; $display("FAIL reset_col: got %b required 1111", col); end
        if (code !== 4'd0) begin tests_failed++; $display("FAIL reset_code: got %0d required 0", code); end
        if (code_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b required 0", code_valid); end
        if (key_held !== 1'b0) begin tests_failed++; $display("FAIL reset_held: got %b required 0", key_held); end
        if (multi_key !== 1'b0) begin tests_failed++; $display("FAIL reset_multi: got %b required 0", multi_key); end
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_single();
        int k;
        int k2;
        clear_counts();
        exp_q.push_back(4'd9);
        keys[2][1] = 1'b1;
        k = 0;
        while (k < 60 && !code_valid) begin
            tick(1);
            k++;
        end
        tests_run += 2;
        if (!code_valid) begin tests_failed++; $display("FAIL single_latency: got no code in %0d cycles required code", k); end
        if (key_held !== 1'b1) begin tests_failed++; $display("FAIL single_held_rise: got %b required 1", key_held); end
        tick(60 - k);
        keys[2][1] = 1'b0;
        k2 = 0;
        while (k2 < 30 && key_held) begin
            tick(1);
            k2++;
        end
        // 2 synchroniser edges then 4 zero samples
        tests_run++;
        if (k2 != 6) begin tests_failed++; $display("FAIL single_held_fall: got %0d cycles required 6", k2); end
        tick(10);
        tests_run += 2;
        if (pops != 1) begin tests_failed++; $display("FAIL single_count: got %0d codes required 1", pops); end
        if (valid_cycles != 1) begin tests_failed++; $display("FAIL single_valid_len: got %0d cycles required 1", valid_cycles); end
    endtask

    task automatic test_sweep();
        clear_counts();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                exp_q.push_back(4'(r * 4 + c));
                press_key(r, c, 40);
            end
        end
        tests_run += 4;
        if (pops != 16) begin tests_failed++; $display("FAIL sweep_count: got %0d required 16", pops); end
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL sweep_left: got %0d pending required 0", exp_q.size()); end
        if (multi_seen != 0) begin tests_failed++; $display("FAIL sweep_multi: got %0d required 0", multi_seen); end
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL sweep_overflow: got %b required 0", overflow); end
    endtask

    task automatic test_bounce();
        clear_counts();
        exp_q.push_back(4'd6);
        for (int i = 0; i < 6; i++) begin
            keys[1][2] = (i % 2 == 0);
            tick(2);
        end
        tests_run++;
        if (pops != 0) begin tests_failed++; $display("FAIL bounce_early: got %0d codes required 0", pops); end
        keys[1][2] = 1'b1;
        tick(60);
        keys[1][2] = 1'b0;
        tick(20);
        tests_run += 2;
        if (pops != 1) begin tests_failed++; $display("FAIL bounce_count: got %0d codes required 1", pops); end
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL bounce_left: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_ghost();
        clear_counts();
        keys[0][0] = 1'b1;
        keys[2][0] = 1'b1;
        tick(40);
        keys[0][0] = 1'b0;
        keys[2][0] = 1'b0;
        tick(20);
        tests_run += 3;
        if (multi_seen != 1) begin tests_failed++; $display("FAIL ghost_multi: got %0d pulses required 1", multi_seen); end
        if (held_seen != 0) begin tests_failed++; $display("FAIL ghost_held: got %0d cycles required 0", held_seen); end
        if (pops != 0) begin tests_failed++; $display("FAIL ghost_code: got %0d codes required 0", pops); end
    endtask

    task automatic test_fifo_full();
        int rs[5] = '{0, 1, 2, 3, 3};
        int cs[5] = '{3, 2, 1, 0, 3};
        clear_counts();
        code_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(4'(rs[i] * 4 + cs[i]));
            press_key(rs[i], cs[i], 40);
        end
        tests_run += 3;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL full_overflow: got %b required 1", overflow); end
        if (code_valid !== 1'b1) begin tests_failed++; $display("FAIL full_valid: got %b required 1", code_valid); end
        if (code !== 4'd3) begin tests_failed++; $display("FAIL full_head: got %0d required 3", code); end
        code_ready = 1'b1;
        tick(10);
        tests_run += 3;
        if (pops != 4) begin tests_failed++; $display("FAIL full_drain: got %0d codes required 4", pops); end
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL full_left: got %0d pending required 0", exp_q.size()); end
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL full_sticky: got %b required 1", overflow); end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_counts();
        code_ready = 1'b0;
        press_key(1, 1, 40);
        press_key(2, 2, 40);
        tests_run++;
        if (code_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_queued: got %b required 1", code_valid); end
        keys[0][0] = 1'b1;
        k = 0;
        while (k < 40 && col === 4'b1111) begin
            tick(1);
            k++;
        end
        tests_run++;
        if (col === 4'b1111) begin tests_failed++; $display("FAIL mid_scan_start: got %b required one-hot", col); end
        // Four settle/sample cycles on column 0, then into the debounce window
        tick(5);
        tests_run++;
        if (col !== 4'b0001) begin tests_failed++; $display("FAIL mid_debounce_col: got %b required 0001", col); end
        reset = 1'b1;
        keys[0][0] = 1'b0;
        tick(1);
        tests_run += 4;
        if (col !== 4'b1111) begin tests_failed++; $display("FAIL mid_col: got %b required 1111", col); end
        if (code_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid: got %b required 0", code_valid); end
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL mid_overflow: got %b required 0", overflow); end
        if (key_held !== 1'b0) begin tests_failed++; $display("FAIL mid_held: got %b required 0", key_held); end
        reset = 1'b0;
        code_ready = 1'b1;
        tick(40);
        tests_run++;
        if (pops != 0) begin tests_failed++; $display("FAIL mid_discard: got %0d codes required 0", pops); end
    endtask

    initial begin
        reset      = 1'b1;
        code_ready = 1'b1;
        keys       = '0;
        test_reset();
        test_single();
        test_sweep();
        test_bounce();
        test_ghost();
        test_fifo_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
